// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with a
// per-register pending (scoreboard) bit for the pipelined Hubris core.
// Decode reserves destination registers, writeback writes data and clears
// pending, and flush drops every outstanding reservation.
// Optional feature macro: REGFILE_MP_WRITE_BYPASS_EN. When it is defined, a
// write is forwarded combinationally to any read port addressing the same
// register in the same cycle.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    // NREG can equal 2**AW, so the bound needs one extra bit.
    localparam logic [AW:0] NREG_L = NREG[AW:0];

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;
    logic [AW:0]     r_busyCnt;

    logic [NREG-1:0] w_pendNext;
    logic [AW:0]     w_cntNext;
    logic            w_wrOk;
    logic            w_rsvOk;
    logic [AW-1:0]   w_rdAddr [NRD];

    // An address is usable when it names an existing register that is not
    // the hardwired zero register.
    function automatic logic addrOk(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_wrOk   = wr_en  && addrOk(wr_addr);
    assign w_rsvOk  = rsv_en && addrOk(rsv_addr);
    assign busy_cnt = r_busyCnt;

    // Next pending state: flush beats reserve, reserve beats write-clear.
    always_comb begin
        w_pendNext = r_pend;
        for (int i = 0; i < NREG; i++) begin
            if (flush)
                w_pendNext[i] = 1'b0;
            else if (w_rsvOk && (rsv_addr == AW'(i)))
                w_pendNext[i] = 1'b1;
            else if (w_wrOk && (wr_addr == AW'(i)))
                w_pendNext[i] = 1'b0;
        end
    end

    // Population count of the next pending vector, registered alongside it.
    always_comb begin
        w_cntNext = '0;
        for (int i = 0; i < NREG; i++)
            w_cntNext = w_cntNext + (AW+1)'(w_pendNext[i]);
    end

    // Split the packed read address bus into per-port addresses.
    always_comb begin
        for (int k = 0; k < NRD; k++)
            w_rdAddr[k] = rd_addr[k*AW +: AW];
    end

    // Combinational read ports; invalid or zero addresses read as idle zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (addrOk(w_rdAddr[k])) begin
`ifdef REGFILE_MP_WRITE_BYPASS_EN
                if (rst_n && w_wrOk && (w_rdAddr[k] == wr_addr)) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                    rd_busy[k]              = w_pendNext[w_rdAddr[k]];
                end else begin
                    rd_data[k*XLEN +: XLEN] = r_regs[w_rdAddr[k]];
                    rd_busy[k]              = r_pend[w_rdAddr[k]];
                end
`else
                rd_data[k*XLEN +: XLEN] = r_regs[w_rdAddr[k]];
                rd_busy[k]              = r_pend[w_rdAddr[k]];
`endif
            end
        end
    end

    // Register storage; flush does not block the data write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wrOk) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Pending bits and their registered count update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_busyCnt <= '0;
        end else begin
            r_pend    <= w_pendNext;
            r_busyCnt <= w_cntNext;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp. One instance
// uses the default parameters, a second uses NREG=24 / NRD=4 to exercise
// out-of-range addresses on a non-power-of-two register count.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    logic [19:0]  rdAddr2;
    logic [127:0] rdData2;
    logic [3:0]   rdBusy2;
    logic         wrEn2;
    logic [4:0]   wrAddr2;
    logic [31:0]  wrData2;
    logic         rsvEn2;
    logic [4:0]   rsvAddr2;
    logic [5:0]   busyCnt2;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        string       name;
        logic        wrEn;
        logic [4:0]  wrAddr;
        logic [31:0] wrData;
        logic        rsvEn;
        logic [4:0]  rsvAddr;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] expD0;
        logic [31:0] expD1;
        logic [1:0]  expBusy;
        logic [5:0]  expCnt;
    } vec_t;

    vec_t vecs [14];

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.NREG(24), .NRD(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr2), .rd_data(rdData2),
        .rd_busy(rdBusy2), .wr_en(wrEn2), .wr_addr(wrAddr2), .wr_data(wrData2),
        .rsv_en(rsvEn2), .rsv_addr(rsvAddr2), .flush(1'b0), .busy_cnt(busyCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive one clock's worth of strobes, then leave only the read addresses.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wr_en    = v.wrEn;
        wr_addr  = v.wrAddr;
        wr_data  = v.wrData;
        rsv_en   = v.rsvEn;
        rsv_addr = v.rsvAddr;
        flush    = v.flush;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        flush   = 1'b0;
        rd_addr = {v.ra1, v.ra0};
        #1;
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"wr0_ignored", 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0};
        vecs[1]  = '{"rsv7",        0, 0, 0, 1, 7, 0, 7, 7, 7, 7, 2'b11, 1};
        vecs[2]  = '{"rsv7_again",  0, 0, 0, 1, 7, 0, 7, 7, 7, 7, 2'b11, 1};
        vecs[3]  = '{"wr7",         1, 7, 32'h55, 0, 0, 0, 7, 8, 32'h55, 8, 2'b00, 0};
        vecs[4]  = '{"rsv_wr9",     1, 9, 32'hA5, 1, 9, 0, 9, 7, 32'hA5, 32'h55, 2'b01, 1};
        vecs[5]  = '{"wr9_clear",   1, 9, 32'h99, 0, 0, 0, 9, 9, 32'h99, 32'h99, 2'b00, 0};
        vecs[6]  = '{"rsv3",        0, 0, 0, 1, 3, 0, 3, 4, 3, 4, 2'b01, 1};
        vecs[7]  = '{"rsv4",        0, 0, 0, 1, 4, 0, 3, 4, 3, 4, 2'b11, 2};
        vecs[8]  = '{"rsv5",        0, 0, 0, 1, 5, 0, 5, 3, 5, 3, 2'b11, 3};
        vecs[9]  = '{"flush_mix",   1, 3, 32'h11, 1, 6, 1, 3, 6, 32'h11, 6, 2'b00, 0};
        vecs[10] = '{"rsv0_ignored",0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0};
        vecs[11] = '{"wr31",        1, 31, 32'hFFFFFFFF, 0, 0, 0, 31, 30, 32'hFFFFFFFF, 30, 2'b00, 0};
        vecs[12] = '{"rsv31",       0, 0, 0, 1, 31, 0, 31, 5, 32'hFFFFFFFF, 5, 2'b01, 1};
        vecs[13] = '{"flush_only",  0, 0, 0, 0, 0, 1, 31, 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0};

        rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0; flush = 0;
        rd_addr = {5'd5, 5'd0};
        wrEn2 = 0; wrAddr2 = 0; wrData2 = 0; rsvEn2 = 0; rsvAddr2 = 0;
        rdAddr2 = {5'd30, 5'd23, 5'd0, 5'd23};
        #12;
        checkOutput("reset_d0", rd_data[31:0], 0);
        checkOutput("reset_d1", rd_data[63:32], 0);
        checkOutput("reset_busy", {30'd0, rd_busy}, 0);
        checkOutput("reset_cnt", {26'd0, busy_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) writeReg(5'(i), i);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            checkOutput($sformatf("pair%0d_d0", i), rd_data[31:0], (i == 0) ? 0 : i);
            checkOutput($sformatf("pair%0d_d1", i), rd_data[63:32], (i == 31) ? 0 : 31 - i);
        end

        for (int n = 0; n < 14; n++) begin
            applyStimulus(vecs[n]);
            checkOutput({vecs[n].name, "_d0"}, rd_data[31:0], vecs[n].expD0);
            checkOutput({vecs[n].name, "_d1"}, rd_data[63:32], vecs[n].expD1);
            checkOutput({vecs[n].name, "_busy"}, {30'd0, rd_busy}, {30'd0, vecs[n].expBusy});
            checkOutput({vecs[n].name, "_cnt"}, {26'd0, busy_cnt}, {26'd0, vecs[n].expCnt});
        end

        // Same-cycle visibility of a write to a register being read.
        @(negedge clk);
        rd_addr = {5'd0, 5'd12};
        wr_en = 1'b1; wr_addr = 12; wr_data = 32'h1234;
        #1;
`ifdef REGFILE_MP_WRITE_BYPASS_EN
        checkOutput("bypass_same_cycle", rd_data[31:0], 32'h1234);
`else
        checkOutput("bypass_same_cycle", rd_data[31:0], 12);
`endif
        checkOutput("bypass_busy", {31'd0, rd_busy[0]}, 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        checkOutput("bypass_next_cycle", rd_data[31:0], 32'h1234);

        // Second instance: out-of-range and zero addresses on 4 ports.
        @(negedge clk);
        wrEn2 = 1'b1; wrAddr2 = 23; wrData2 = 32'hABCD;
        @(posedge clk); #1;
        wrAddr2 = 30; wrData2 = 32'hBAD;
        rsvEn2 = 1'b1; rsvAddr2 = 30;
        @(posedge clk); #1;
        wrEn2 = 1'b0; rsvEn2 = 1'b0;
        #1;
        checkOutput("p4_d0", rdData2[31:0], 32'hABCD);
        checkOutput("p4_d1", rdData2[63:32], 0);
        checkOutput("p4_d2", rdData2[95:64], 32'hABCD);
        checkOutput("p4_d3_addr30", rdData2[127:96], 0);
        checkOutput("p4_busy", {28'd0, rdBusy2}, 0);
        checkOutput("p4_cnt", {26'd0, busyCnt2}, 0);
        @(negedge clk);
        rsvEn2 = 1'b1; rsvAddr2 = 23;
        @(posedge clk); #1;
        rsvEn2 = 1'b0;
        #1;
        checkOutput("p4_rsv23_busy", {28'd0, rdBusy2}, 32'b0101);
        checkOutput("p4_rsv23_cnt", {26'd0, busyCnt2}, 1);

        // Asynchronous reset in the middle of activity.
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 31;
        @(posedge clk); #1;
        rsv_en = 1'b0;
        rd_addr = {5'd12, 5'd31};
        #1;
        checkOutput("pre_reset_cnt", {26'd0, busy_cnt}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_d0", rd_data[31:0], 0);
        checkOutput("midreset_d1", rd_data[63:32], 0);
        checkOutput("midreset_busy", {30'd0, rd_busy}, 0);
        checkOutput("midreset_cnt", {26'd0, busy_cnt}, 0);
        checkOutput("midreset_p4_cnt", {26'd0, busyCnt2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        writeReg(5, 32'h77);
        rd_addr = {5'd12, 5'd5};
        #1;
        checkOutput("post_reset_wr5", rd_data[31:0], 32'h77);
        checkOutput("post_reset_r12", rd_data[63:32], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file with a per-register pending (scoreboard) bit, for the pipelined Hubris core.
- Replaces the fixed 2-read/1-write 32x32 register file.
- Decode issues reservations and read addresses; writeback writes data and clears pending.
- Flush drops all outstanding reservations.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (2..64; not required to be a power of two).
- NRD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as zero and cannot be written or reserved.
- Derived: AW = $clog2(NREG) (not a port-level parameter).

Ports:
- clk      in   1         system clock, all state updates on rising edge
- rst_n    in   1         asynchronous active-low reset
- rd_addr  in   NRD*AW    read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- rd_busy  out  NRD       pending bit of the register addressed on port k
- wr_en    in   1         write strobe
- wr_addr  in   AW        write address
- wr_data  in   XLEN      write data
- rsv_en   in   1         reserve, i.e. mark register pending
- rsv_addr in   AW        register to reserve
- flush    in   1         clear all pending bits
- busy_cnt out  AW+1      number of registers currently pending

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, busy_cnt 0. Reads stay combinational during reset and return 0.
- Reads are combinational, with zero latency from rd_addr to rd_data/rd_busy.
- Address >= NREG:
  - read returns 0 data and busy 0;
  - write and reservation are ignored.
- ZERO_REG=1, address 0:
  - read returns 0 and busy 0;
  - wr_en/rsv_en to address 0 are ignored.
- Write: on a rising clk edge with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Reserve: on a rising clk edge with rsv_en=1, pending[rsv_addr] <= 1.
- Same-edge priority for a pending bit, highest first:
  - flush -> 0;
  - rsv_en on the matching address -> 1;
  - wr_en on the matching address -> 0;
  - otherwise hold.
- wr_en and rsv_en to the same address on the same edge: data is written and the register stays pending (a newer producer owns it).
- flush does not block the data write; the register write still happens.
- busy_cnt is a registered population count of the pending bits, updated on the same edge as the pending bits. It must equal popcount(pending) after every edge.
  - Reserving an already-pending register does not increment busy_cnt.
  - Writing a non-pending register does not decrement busy_cnt.
- Reset asserted mid-operation clears everything immediately; the first edge after rst_n rises behaves normally.
- Multiple read ports addressing the same register return identical values.

Optional Feature:
- Macro: REGFILE_MP_WRITE_BYPASS_EN.
- Defined:
  - when wr_en=1 and rd_addr[k]==wr_addr (valid, non-zero when ZERO_REG), rd_data[k] shows wr_data in the same cycle, combinationally;
  - rd_busy[k] shows the post-edge value: 0, unless rsv_en on the same address or flush rules apply (flush -> 0).
- Undefined: reads always show the pre-edge register and pending state; the new value is visible the cycle after the edge.

Test Plan:
- Reset with defaults, rd_addr = {5, 0} -> rd_data 0, rd_busy 0, busy_cnt 0; assert rst_n low mid-run after writes -> all reads 0 immediately.
- Write reg i = i for i = 0..31 over 32 cycles, then read all pairs (i, 31-i) -> data i and 31-i, except reg 0 reads 0; a write of 0xDEADBEEF to reg 0 reads back 0.
- Reserve reg 7 -> rd_busy 1, busy_cnt 1.
  - Reserve reg 7 again -> busy_cnt stays 1.
  - wr_en reg 7 = 0x55 -> busy 0, busy_cnt 0, data 0x55.
- Same edge: rsv_en reg 9 and wr_en reg 9 = 0xA5 -> data 0xA5, busy stays 1, busy_cnt 1.
- Reserve regs 3, 4, 5 (busy_cnt 3).
  - flush with rsv_en reg 6 and wr_en reg 3 = 0x11 -> all busy 0, busy_cnt 0, reg 3 = 0x11.
- With REGFILE_MP_WRITE_BYPASS_EN: wr_en reg 12 = 0x1234 while rd_addr[0] = 12 -> rd_data 0x1234 in the same cycle.
  - Without the macro -> old value this cycle, 0x1234 next cycle.
  - Repeat with NRD=4, NREG=24: reading address 30 -> 0, busy 0.
